// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine
//   Loads an N x N unsigned image and a K x K unsigned kernel over two
//   valid/ready streams, computes every valid-convolution output in raster
//   order, and streams the requantised, saturated results downstream.
//   mode 0 accumulates one product per cycle (K*K cycles per output).
//   mode 1 accumulates one kernel row per cycle (K cycles per output).
//   Both modes produce bit-identical result sequences.
//
// Ports
//   clk_i      rising-edge clock
//   rst_ni     synchronous active-low reset
//   start_i    job start pulse, honoured only while idle
//   mode_i     0 = single MAC, 1 = row-parallel; latched at start
//   busy_o     high whenever the engine is not idle
//   a_*        image pixel stream, raster order
//   b_*        kernel coefficient stream, raster order
//   c_*        result stream; c_last_o marks the final result of a job
//   done_o     one-cycle pulse after the final result handshake
module conv2d_stream_engine #(
  parameter int DW    = 8,
  parameter int N     = 4,
  parameter int K     = 3,
  parameter int ACC_W = 20,
  parameter int SHIFT = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          mode_i,
  output logic          busy_o,
  input  logic          a_valid_i,
  input  logic [DW-1:0] a_data_i,
  output logic          a_ready_o,
  input  logic          b_valid_i,
  input  logic [DW-1:0] b_data_i,
  output logic          b_ready_o,
  output logic          c_valid_o,
  output logic [DW-1:0] c_data_o,
  output logic          c_last_o,
  input  logic          c_ready_i,
  output logic          done_o
);

  localparam int NPIX  = N * N;
  localparam int NCOEF = K * K;
  localparam int IW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int KIW   = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int AW    = $clog2(NPIX + 1);
  localparam int BW    = $clog2(NCOEF + 1);
  localparam int PW    = $clog2(N + 1);
  localparam int KW    = $clog2(K + 1);

  localparam logic [ACC_W-1:0] MAXV    = ACC_W'((64'd1 << DW) - 64'd1);
  localparam logic [PW-1:0]    LASTPOS = PW'(N - K);
  localparam logic [KW-1:0]    LASTK   = KW'(K - 1);
  localparam logic [AW-1:0]    AFULL   = AW'(NPIX);
  localparam logic [AW-1:0]    ALAST   = AW'(NPIX - 1);
  localparam logic [BW-1:0]    BFULL   = BW'(NCOEF);
  localparam logic [BW-1:0]    BLAST   = BW'(NCOEF - 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, OUTPUT, DONE} state_e;

  state_e            stateQ;
  logic              modeQ;
  logic [AW-1:0]     aCntQ;
  logic [BW-1:0]     bCntQ;
  logic [PW-1:0]     rQ, cQ;
  logic [KW-1:0]     iQ, jQ;
  logic [ACC_W-1:0]  accQ;
  logic              busyQ, aReadyQ, bReadyQ, cValidQ, cLastQ, doneQ;
  logic [DW-1:0]     cDataQ;
  logic [DW-1:0]     imgQ [NPIX];
  logic [DW-1:0]     kerQ [NCOEF];

  logic [ACC_W-1:0]  termD, accD, shiftD;
  logic [DW-1:0]     satD;
  logic              lastStepD, lastOutD;

  // Products for the current step. In mode 0 only column jQ of kernel row iQ
  // contributes; in mode 1 the whole row is summed in one cycle. Operands are
  // widened before multiplying so nothing is lost ahead of the accumulator.
  always_comb begin
    termD = '0;
    for (int jj = 0; jj < K; jj++) begin
      if (modeQ || (jj == int'(jQ))) begin
        termD = termD
              + ACC_W'(imgQ[IW'((int'(rQ) + int'(iQ)) * N + int'(cQ) + jj)])
              * ACC_W'(kerQ[KIW'(int'(iQ) * K + jj)]);
      end
    end
    accD      = accQ + termD;
    shiftD    = accD >> SHIFT;
    satD      = (shiftD > MAXV) ? {DW{1'b1}} : shiftD[DW-1:0];
    lastStepD = (iQ == LASTK) && (modeQ || (jQ == LASTK));
    lastOutD  = (rQ == LASTPOS) && (cQ == LASTPOS);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stateQ  <= IDLE;
      modeQ   <= 1'b0;
      aCntQ   <= '0;
      bCntQ   <= '0;
      rQ      <= '0;
      cQ      <= '0;
      iQ      <= '0;
      jQ      <= '0;
      accQ    <= '0;
      busyQ   <= 1'b0;
      aReadyQ <= 1'b0;
      bReadyQ <= 1'b0;
      cValidQ <= 1'b0;
      cLastQ  <= 1'b0;
      cDataQ  <= '0;
      doneQ   <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (start_i) begin
            modeQ   <= mode_i;
            stateQ  <= LOAD;
            busyQ   <= 1'b1;
            aReadyQ <= 1'b1;
            bReadyQ <= 1'b1;
            aCntQ   <= '0;
            bCntQ   <= '0;
          end
        end
        LOAD: begin
          if (a_valid_i && aReadyQ) begin
            imgQ[IW'(aCntQ)] <= a_data_i;
            aCntQ            <= aCntQ + AW'(1);
            if (aCntQ == ALAST) aReadyQ <= 1'b0;
          end
          if (b_valid_i && bReadyQ) begin
            kerQ[KIW'(bCntQ)] <= b_data_i;
            bCntQ             <= bCntQ + BW'(1);
            if (bCntQ == BLAST) bReadyQ <= 1'b0;
          end
          // Counters are checked as registered, so COMPUTE starts the cycle
          // after the last transfer lands in the buffers.
          if ((aCntQ == AFULL) && (bCntQ == BFULL)) begin
            stateQ <= COMPUTE;
            accQ   <= '0;
            rQ     <= '0;
            cQ     <= '0;
            iQ     <= '0;
            jQ     <= '0;
          end
        end
        COMPUTE: begin
          accQ <= accD;
          if (lastStepD) begin
            iQ      <= '0;
            jQ      <= '0;
            stateQ  <= OUTPUT;
            cValidQ <= 1'b1;
            cDataQ  <= satD;
            cLastQ  <= lastOutD;
          end else if (!modeQ && (jQ != LASTK)) begin
            jQ <= jQ + KW'(1);
          end else begin
            jQ <= '0;
            iQ <= iQ + KW'(1);
          end
        end
        OUTPUT: begin
          if (c_ready_i) begin
            cValidQ <= 1'b0;
            cLastQ  <= 1'b0;
            if (cLastQ) begin
              stateQ <= DONE;
              doneQ  <= 1'b1;
            end else begin
              stateQ <= COMPUTE;
              accQ   <= '0;
              if (cQ == LASTPOS) begin
                cQ <= '0;
                rQ <= rQ + PW'(1);
              end else begin
                cQ <= cQ + PW'(1);
              end
            end
          end
        end
        DONE: begin
          doneQ  <= 1'b0;
          busyQ  <= 1'b0;
          stateQ <= IDLE;
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign busy_o    = busyQ;
  assign a_ready_o = aReadyQ;
  assign b_ready_o = bReadyQ;
  assign c_valid_o = cValidQ;
  assign c_data_o  = cDataQ;
  assign c_last_o  = cLastQ;
  assign done_o    = doneQ;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// tb_conv2d_stream_engine
//   Scoreboard bench for conv2d_stream_engine. Three instances share the
//   input streams: dut0 (N=4,K=3,SHIFT=0), dut1 (N=4,K=3,SHIFT=12) and
//   dut2 (N=5,K=2,ACC_W=18). Only the selected instance is started, so the
//   idle ones never assert ready and never take stream data.
module tb_conv2d_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN, modeI, aValid, bValid, cReady;
  logic [7:0] aData, bData;
  logic [2:0] startV;
  logic       busyW [3];
  logic       aReadyW [3];
  logic       bReadyW [3];
  logic       cValidW [3];
  logic       cLastW [3];
  logic       doneW [3];
  logic [7:0] cDataW [3];
  logic [1:0] sel = 2'd0;

  logic       busy, aReady, bReady, cValid, cLast, done;
  logic [7:0] cData;
  assign busy   = busyW[sel];
  assign aReady = aReadyW[sel];
  assign bReady = bReadyW[sel];
  assign cValid = cValidW[sel];
  assign cLast  = cLastW[sel];
  assign done   = doneW[sel];
  assign cData  = cDataW[sel];

  conv2d_stream_engine #(.DW(8), .N(4), .K(3), .ACC_W(20), .SHIFT(0)) dut0 (
    .clk_i(clk), .rst_ni(rstN), .start_i(startV[0]), .mode_i(modeI), .busy_o(busyW[0]),
    .a_valid_i(aValid), .a_data_i(aData), .a_ready_o(aReadyW[0]),
    .b_valid_i(bValid), .b_data_i(bData), .b_ready_o(bReadyW[0]),
    .c_valid_o(cValidW[0]), .c_data_o(cDataW[0]), .c_last_o(cLastW[0]),
    .c_ready_i(cReady), .done_o(doneW[0]));

  conv2d_stream_engine #(.DW(8), .N(4), .K(3), .ACC_W(20), .SHIFT(12)) dut1 (
    .clk_i(clk), .rst_ni(rstN), .start_i(startV[1]), .mode_i(modeI), .busy_o(busyW[1]),
    .a_valid_i(aValid), .a_data_i(aData), .a_ready_o(aReadyW[1]),
    .b_valid_i(bValid), .b_data_i(bData), .b_ready_o(bReadyW[1]),
    .c_valid_o(cValidW[1]), .c_data_o(cDataW[1]), .c_last_o(cLastW[1]),
    .c_ready_i(cReady), .done_o(doneW[1]));

  conv2d_stream_engine #(.DW(8), .N(5), .K(2), .ACC_W(18), .SHIFT(0)) dut2 (
    .clk_i(clk), .rst_ni(rstN), .start_i(startV[2]), .mode_i(modeI), .busy_o(busyW[2]),
    .a_valid_i(aValid), .a_data_i(aData), .a_ready_o(aReadyW[2]),
    .b_valid_i(bValid), .b_data_i(bData), .b_ready_o(bReadyW[2]),
    .c_valid_o(cValidW[2]), .c_data_o(cDataW[2]), .c_last_o(cLastW[2]),
    .c_ready_i(cReady), .done_o(doneW[2]));

  int checks = 0;
  int errors = 0;
  int imgA [25];
  int kerB [9];
  int curN, curK, curShift;
  int expData [$];
  int expLast [$];
  int riseEdges [$];
  int cyc = 0;
  int lastLoadEdge = 0;
  int lastHsEdge = 0;
  int outCount = 0;
  int doneCount = 0;
  bit prevStall = 1'b0;
  bit prevValid = 1'b0;
  int prevData = 0;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference convolution for one output position of the selected instance.
  function automatic int refConv(input int r, input int c);
    longint acc = 0;
    for (int i = 0; i < curK; i++)
      for (int j = 0; j < curK; j++)
        acc += longint'(imgA[(r + i) * curN + c + j]) * longint'(kerB[i * curK + j]);
    acc = acc >> curShift;
    return (acc > 255) ? 255 : int'(acc);
  endfunction

  // Edge counter; at a negedge it holds the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every result handshake, checks that
  // a stalled result holds, logs c_valid rise edges and load completion, and
  // checks that done follows the final handshake by one cycle.
  always @(negedge clk) begin
    if (cValid && cReady) begin
      if (expData.size() == 0) begin
        checkOutput("unexpectedResult", int'(cData), -1);
      end else begin
        checkOutput("cData", int'(cData), expData.pop_front());
        checkOutput("cLast", int'(cLast), expLast.pop_front());
      end
      outCount++;
      lastHsEdge = cyc + 1;
    end
    if (cValid === 1'b1 && !prevValid) riseEdges.push_back(cyc);
    if (prevStall) begin
      checkOutput("cValidHeld", int'(cValid), 1);
      checkOutput("cDataHeld", int'(cData), prevData);
    end
    prevStall = (cValid === 1'b1) && !cReady;
    prevValid = (cValid === 1'b1);
    prevData  = int'(cData);
    if (done === 1'b1) begin
      doneCount++;
      checkOutput("doneTiming", cyc, lastHsEdge);
    end
    if (aValid && aReady === 1'b1) lastLoadEdge = cyc + 1;
    if (bValid && bReady === 1'b1) lastLoadEdge = cyc + 1;
  end

  task automatic sendA(input int cnt, input bit gaps);
    bit hs;
    int w;
    for (int k = 0; k < cnt; k++) begin
      aValid = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      aValid = 1'b1;
      aData  = 8'(imgA[k]);
      hs = 1'b0;
      w  = 0;
      while (!hs && w < 200) begin
        @(negedge clk);
        hs = (aReady === 1'b1);
        @(posedge clk); #1;
        w++;
      end
      if (!hs) begin
        checkOutput("aTimeout", 0, 1);
        break;
      end
    end
    aValid = 1'b0;
  endtask

  task automatic sendB(input int cnt, input bit gaps);
    bit hs;
    int w;
    for (int k = 0; k < cnt; k++) begin
      bValid = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bValid = 1'b1;
      bData  = 8'(kerB[k]);
      hs = 1'b0;
      w  = 0;
      while (!hs && w < 200) begin
        @(negedge clk);
        hs = (bReady === 1'b1);
        @(posedge clk); #1;
        w++;
      end
      if (!hs) begin
        checkOutput("bTimeout", 0, 1);
        break;
      end
    end
    bValid = 1'b0;
  endtask

  // Starts a job on one instance, fills the scoreboard from the reference
  // model and loads both buffers. order: 0 = streams concurrent, 1 = kernel
  // first with random gaps, 2 = image first then a stray extra pixel offered
  // while the kernel loads.
  task automatic applyStimulus(input int dutSel, input bit mode, input int order);
    sel      = 2'(dutSel);
    curN     = (dutSel == 2) ? 5 : 4;
    curK     = (dutSel == 2) ? 2 : 3;
    curShift = (dutSel == 1) ? 12 : 0;
    riseEdges.delete();
    for (int r = 0; r <= curN - curK; r++)
      for (int c = 0; c <= curN - curK; c++) begin
        expData.push_back(refConv(r, c));
        expLast.push_back((r == curN - curK && c == curN - curK) ? 1 : 0);
      end
    modeI          = mode;
    startV[dutSel] = 1'b1;
    @(posedge clk); #1;
    startV = '0;
    case (order)
      0: fork
           sendA(curN * curN, 1'b0);
           sendB(curK * curK, 1'b0);
         join
      1: begin
           sendB(curK * curK, 1'b1);
           sendA(curN * curN, 1'b1);
         end
      default: begin
           sendA(curN * curN, 1'b0);
           aValid = 1'b1;
           aData  = 8'hEE;
           @(negedge clk);
           checkOutput("aReadyLow", int'(aReady), 0);
           @(posedge clk); #1;
           sendB(curK * curK, 1'b0);
           aValid = 1'b0;
         end
    endcase
  endtask

  // Runs the result side until done, optionally stalling result stallAt for
  // ten cycles, then checks the engine came back to idle.
  task automatic waitJob(input int stallAt);
    int startDone = doneCount;
    int n = 0;
    int stallLeft = 10;
    cReady = 1'b1;
    while (doneCount == startDone && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (stallAt >= 0 && stallLeft > 0 && cValid === 1'b1 && outCount == stallAt) begin
        cReady = 1'b0;
        stallLeft--;
      end else begin
        cReady = 1'b1;
      end
    end
    if (n >= 2000) checkOutput("jobTimeout", 0, 1);
    @(negedge clk);
    checkOutput("doneOnePulse", int'(done), 0);
    checkOutput("busyIdle", int'(busy), 0);
    checkOutput("scoreboardEmpty", expData.size(), 0);
    @(posedge clk); #1;
  endtask

  // Every c_valid rise of a free-flowing job lands a whole number of output
  // periods after the last load transfer.
  task automatic checkTiming(input bit mode);
    int per  = mode ? curK + 1 : curK * curK + 1;
    int nOut = (curN - curK + 1) * (curN - curK + 1);
    checkOutput("riseCount", riseEdges.size(), nOut);
    for (int k = 0; k < riseEdges.size(); k++)
      checkOutput("riseLatency", riseEdges[k] - lastLoadEdge, (k + 1) * per);
  endtask

  task automatic fillRamp();
    for (int k = 0; k < 16; k++) imgA[k] = k + 1;
    for (int k = 0; k < 9; k++) kerB[k] = 1;
  endtask

  initial begin
    int doneBefore;
    rstN = 1'b0; startV = '0; modeI = 1'b0; aValid = 1'b0; bValid = 1'b0;
    aData = '0; bData = '0; cReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstAReady", int'(aReady), 0);
    checkOutput("rstBReady", int'(bReady), 0);
    checkOutput("rstCValid", int'(cValid), 0);
    checkOutput("rstCLast", int'(cLast), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstCData", int'(cData), 0);
    rstN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] ramp image, unit kernel, both modes");
    fillRamp();
    applyStimulus(0, 1'b0, 0); waitJob(-1); checkTiming(1'b0);
    applyStimulus(0, 1'b1, 0); waitJob(-1); checkTiming(1'b1);

    $display("[TB] saturation and requantising shift");
    for (int k = 0; k < 16; k++) imgA[k] = 255;
    for (int k = 0; k < 9; k++) kerB[k] = 255;
    applyStimulus(0, 1'b0, 0); waitJob(-1); checkTiming(1'b0);
    applyStimulus(1, 1'b1, 0); waitJob(-1); checkTiming(1'b1);

    $display("[TB] backpressure and load ordering");
    fillRamp();
    applyStimulus(0, 1'b1, 0); waitJob(1);
    applyStimulus(0, 1'b0, 1); waitJob(-1); checkTiming(1'b0);
    applyStimulus(0, 1'b1, 2); waitJob(-1); checkTiming(1'b1);

    $display("[TB] reset mid-compute, recovery, start while busy");
    applyStimulus(0, 1'b0, 0);
    repeat (3) begin @(posedge clk); #1; end
    doneBefore = doneCount;
    rstN = 1'b0;
    expData.delete();
    expLast.delete();
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("rstMidCValid", int'(cValid), 0);
    checkOutput("rstMidBusy", int'(busy), 0);
    repeat (20) begin @(posedge clk); #1; end
    checkOutput("noDoneAfterReset", doneCount, doneBefore);
    for (int k = 0; k < 16; k++) imgA[k] = int'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++) kerB[k] = int'($urandom_range(0, 255));
    applyStimulus(0, 1'b0, 0);
    startV[0] = 1'b1;
    modeI     = 1'b1;
    @(posedge clk); #1;
    startV = '0;
    waitJob(-1); checkTiming(1'b0);

    $display("[TB] N=5 K=2 random data, row-parallel");
    for (int k = 0; k < 25; k++) imgA[k] = int'($urandom_range(0, 255));
    for (int k = 0; k < 4; k++) kerB[k] = int'($urandom_range(0, 255));
    applyStimulus(2, 1'b1, 0); waitJob(-1); checkTiming(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2d_stream_engine.md
Name: conv2d_stream_engine

Overview:
- Parametrised successor to the fixed 4x4-image, 3x3-kernel, 2x2-result convolution block.
- Loads an N x N unsigned image and a K x K unsigned kernel over valid/ready streams.
- Computes all (N-K+1)^2 valid-convolution outputs in either a single-MAC or a K-MAC row-parallel mode.
- Streams requantised, saturated results to the downstream store stage with backpressure.

Parameters:
- DW, 8, pixel, kernel and result width (unsigned).
- N, 4, image side length; must satisfy N >= K.
- K, 3, kernel side length; must satisfy K >= 1.
- ACC_W, 20, accumulator width; must be >= 2*DW + ceil(log2(K*K)).
- SHIFT, 0, right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle job start pulse; honoured only in IDLE.
- mode  in  1  0 = single MAC (one product per cycle), 1 = row-parallel (K products per cycle); sampled at start.
- busy  out  1  high in every state except IDLE.
- a_valid  in  1  image pixel valid.
- a_data  in  DW  image pixel, raster order, row 0 column 0 first.
- a_ready  out  1  image stream ready.
- b_valid  in  1  kernel coefficient valid.
- b_data  in  DW  kernel coefficient, raster order.
- b_ready  out  1  kernel stream ready.
- c_valid  out  1  result valid.
- c_data  out  DW  result value.
- c_last  out  1  marks the final result of the job.
- c_ready  in  1  downstream ready.
- done  out  1  one-cycle pulse after the final result handshake.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - State returns to IDLE.
  - All counters and the accumulator clear.
  - busy, a_ready, b_ready, c_valid, c_last and done are 0; c_data is 0.
  - Reset mid-job abandons the job; no done pulse is produced.
- FSM states: IDLE, LOAD, COMPUTE, OUTPUT, DONE.
- IDLE:
  - start == 1 latches mode and moves to LOAD.
  - start in any other state is ignored.
- LOAD:
  - a_ready = 1 until N*N pixels have been accepted, then 0.
  - b_ready = 1 until K*K coefficients have been accepted, then 0.
  - The two streams load independently and may interleave or overlap.
  - A transfer occurs on valid & ready.
  - The state moves to COMPUTE on the cycle after both buffers are full.
- COMPUTE:
  - Output index (r, c) runs in raster order; r and c each run 0..N-K.
  - Mode 0: K*K cycles per output, one product A[r+i][c+j]*B[i][j] per cycle, i-major order.
  - Mode 1: K cycles per output, one kernel row i per cycle, K products summed that cycle.
  - The accumulator clears at the start of each output.
  - Products are unsigned and the accumulator is unsigned, ACC_W bits, with no wrap given a legal ACC_W.
- OUTPUT:
  - Entered the cycle after the last accumulate cycle.
  - c_data = min(acc >> SHIFT, 2^DW - 1).
  - c_valid = 1 and c_data is held stable until c_ready == 1.
  - c_last = 1 only with the final (N-K, N-K) result.
  - On the handshake, either go to COMPUTE for the next output or to DONE after the last one.
  - There is no compute overlap: c_ready low stalls the engine indefinitely.
- DONE: done = 1 for exactly one cycle, then IDLE. busy drops in the same cycle as the IDLE entry.
- Latency per output, from COMPUTE entry to c_valid rising:
  - Mode 0: K*K + 1 cycles.
  - Mode 1: K + 1 cycles.
- Job throughput with c_ready held high:
  - Mode 0: (N-K+1)^2 * (K*K + 1) cycles after LOAD completes.
  - Mode 1: (N-K+1)^2 * (K + 1) cycles after LOAD completes.
- Mode 0 and mode 1 produce bit-identical result sequences.
- Degenerate N == K: one output, with c_last asserted on it.
- Buffers are overwritten only by a new job's LOAD; no read-back port exists.

Test Plan:
- Mode 0, N=4, K=3, SHIFT=0: A=1..16 raster, B all 1 -> results 54, 63, 90, 99 in order; c_last on 99; done one cycle after the final handshake; 40 cycles from COMPUTE entry to the last c_valid with c_ready=1.
- Mode 1, same data -> identical 54, 63, 90, 99; each c_valid rises 4 cycles after its compute start; 16 cycles total.
- Saturation: A all 255, B all 255, SHIFT=0 -> four results of 255. With SHIFT=12 -> 585225>>12 = 142 each.
- Backpressure and load ordering:
  - Hold c_ready low 10 cycles on result 2 -> c_data stays 63, no further compute occurs, and the result order is unchanged.
  - Feed B entirely before A, with random valid gaps -> same results.
  - a_ready drops after the 16th pixel; an extra a_valid is not accepted.
- Reset and start handling:
  - Drive rst low during COMPUTE -> next cycle c_valid=0, busy=0, no done.
  - A new job afterwards gives correct results.
  - A start pulse while busy is ignored.
- Parameter sweep: N=5, K=2, DW=8, ACC_W=18, mode 1 with random data -> 16 results match the reference model, c_last on the 16th.
